// File: rtl/id_stage_pipe.sv
// Decode stage with a registered decode/execute boundary.
// Decodes OP, OP-IMM, LOAD, STORE and LUI and resolves operands through
// priority forwarding, with fetch/execute valid-ready handshakes.
// A load-use hazard stalls fetch and inserts a bubble, and a saturating
// counter records how many cycles were lost to load-use stalls.
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int FWD_N = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // fetch side
  input  logic                   if_valid_i,
  output logic                   if_ready_o,
  input  logic [XLEN-1:0]        if_pc_i,
  input  logic [31:0]            if_inst_i,
  // register file
  output logic [4:0]             id_reg1_raddr_o,
  output logic [4:0]             id_reg2_raddr_o,
  input  logic [XLEN-1:0]        regs_reg1_rdata_i,
  input  logic [XLEN-1:0]        regs_reg2_rdata_i,
  // forwarding sources, index 0 has the highest priority
  input  logic [FWD_N-1:0]       fwd_valid_i,
  input  logic [5*FWD_N-1:0]     fwd_waddr_i,
  input  logic [XLEN*FWD_N-1:0]  fwd_data_i,
  // outstanding load in execute
  input  logic                   ex_load_pending_i,
  input  logic [4:0]             ex_load_waddr_i,
  // pipeline control
  input  logic                   flush_i,
  input  logic                   ex_ready_i,
  // decode/execute boundary register
  output logic                   id_valid_o,
  output logic [XLEN-1:0]        id_pc_o,
  output logic [XLEN-1:0]        id_op_a_o,
  output logic [XLEN-1:0]        id_op_b_o,
  output logic [XLEN-1:0]        id_store_data_o,
  output logic [4:0]             id_reg_waddr_o,
  output logic                   id_reg_we_o,
  output logic                   id_mem_re_o,
  output logic                   id_mem_we_o,
  output logic                   id_illegal_o,
  output logic [4:0]             id_ALUctrl_o,
  output logic [CNT_W-1:0]       id_stall_cnt_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = if_inst_i[6:0];
  assign rd     = if_inst_i[11:7];
  assign funct3 = if_inst_i[14:12];
  assign rs1    = if_inst_i[19:15];
  assign rs2    = if_inst_i[24:20];
  assign funct7 = if_inst_i[31:25];

  assign id_reg1_raddr_o = rs1;
  assign id_reg2_raddr_o = rs2;

  // sign-extended immediates
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;

  assign imm_i = XLEN'($signed(if_inst_i[31:20]));
  assign imm_s = XLEN'($signed({if_inst_i[31:25], if_inst_i[11:7]}));
  assign imm_u = XLEN'($signed({if_inst_i[31:12], 12'b0}));

  // decoded controls
  logic       is_op;
  logic       is_op_imm;
  logic       is_load;
  logic       is_store;
  logic       is_lui;
  logic       illegal;
  logic       re1;
  logic       re2;
  logic       reg_we;
  logic [4:0] alu_ctrl;

  // opcode classification, read enables, write enable and ALU control
  always_comb begin
    is_op     = (opcode == OPC_OP);
    is_op_imm = (opcode == OPC_OP_IMM);
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_lui    = (opcode == OPC_LUI);
    illegal   = !(is_op || is_op_imm || is_load || is_store || is_lui);
    re1       = is_op || is_op_imm || is_load || is_store;
    re2       = is_op || is_store;
    reg_we    = is_op || is_op_imm || is_load || is_lui;
    alu_ctrl  = 5'b00000;
    if (is_op) begin
      alu_ctrl = {1'b0, funct7[5], funct3};
    end else if (is_op_imm) begin
      // only the shift-right group uses f7[5] (logical vs arithmetic)
      alu_ctrl = {1'b0, (funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
    end else if (is_lui) begin
      alu_ctrl = 5'b10000;
    end
  end

  // resolved source operands
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  // rs1: x0 is zero, else lowest-index matching forward source, else regfile.
  // Walking from the highest index down lets the lowest match overwrite.
  always_comb begin
    rs1_val = regs_reg1_rdata_i;
    for (int k = FWD_N - 1; k >= 0; k--) begin
      if (fwd_valid_i[k] && (fwd_waddr_i[5*k +: 5] == rs1)) begin
        rs1_val = fwd_data_i[XLEN*k +: XLEN];
      end
    end
    if (rs1 == 5'd0) begin
      rs1_val = '0;
    end
  end

  // rs2: same resolution order as rs1
  always_comb begin
    rs2_val = regs_reg2_rdata_i;
    for (int k = FWD_N - 1; k >= 0; k--) begin
      if (fwd_valid_i[k] && (fwd_waddr_i[5*k +: 5] == rs2)) begin
        rs2_val = fwd_data_i[XLEN*k +: XLEN];
      end
    end
    if (rs2 == 5'd0) begin
      rs2_val = '0;
    end
  end

  // operand selection
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  // op_a is rs1 except LUI; op_b is rs2 for OP, otherwise the format's immediate
  always_comb begin
    op_a = is_lui ? '0 : rs1_val;
    if (is_op) begin
      op_b = rs2_val;
    end else if (is_store) begin
      op_b = imm_s;
    end else if (is_lui) begin
      op_b = imm_u;
    end else begin
      op_b = imm_i;
    end
  end

  // hazard detection and handshakes
  logic stall;
  logic accept;
  logic load_out;

  // a pending load to x0 never produces data anyone waits on
  assign stall = if_valid_i && ex_load_pending_i && (ex_load_waddr_i != 5'd0) &&
                 ((re1 && (rs1 == ex_load_waddr_i)) ||
                  (re2 && (rs2 == ex_load_waddr_i)));

  assign load_out   = !id_valid_o || ex_ready_i;
  assign if_ready_o = !stall && load_out;
  assign accept     = if_valid_i && if_ready_o;

  // boundary register: flush kills, otherwise load on a free slot, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_o      <= 1'b0;
      id_pc_o         <= '0;
      id_op_a_o       <= '0;
      id_op_b_o       <= '0;
      id_store_data_o <= '0;
      id_reg_waddr_o  <= 5'd0;
      id_reg_we_o     <= 1'b0;
      id_mem_re_o     <= 1'b0;
      id_mem_we_o     <= 1'b0;
      id_illegal_o    <= 1'b0;
      id_ALUctrl_o    <= 5'd0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
    end else if (load_out) begin
      id_valid_o <= accept;
      if (accept) begin
        id_pc_o         <= if_pc_i;
        id_op_a_o       <= op_a;
        id_op_b_o       <= op_b;
        id_store_data_o <= rs2_val;
        id_reg_waddr_o  <= rd;
        id_reg_we_o     <= reg_we;
        id_mem_re_o     <= is_load;
        id_mem_we_o     <= is_store;
        id_illegal_o    <= illegal;
        id_ALUctrl_o    <= alu_ctrl;
      end
    end
  end

  // load-use stall counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_stall_cnt_o <= '0;
    end else if (stall && if_valid_i && !flush_i && (id_stall_cnt_o != '1)) begin
      id_stall_cnt_o <= id_stall_cnt_o + 1'b1;
    end
  end

endmodule
